cpu_dbg_ctrl: RTL and testbench



---
 rtl/cpu_dbg_pkg.sv | 29 ++
 rtl/dbg_word_ser.sv | 47 ++++
 rtl/cpu_dbg_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_dbg_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared constants and state encoding for the CPU debug sequencer.
package cpu_dbg_pkg;

   localparam logic [7:0] CMD_RUN   = 8'h52;
   localparam logic [7:0] CMD_HALT  = 8'h48;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] CMD_RST   = 8'h50;
   localparam logic [7:0] CMD_DUMP  = 8'h44;
   localparam logic [7:0] ERR_REPLY = 8'h3F;

   localparam int unsigned IDX_W = 5;

   typedef enum logic [2:0] {
      ST_RST,
      ST_IDLE,
      ST_RUN,
      ST_STEP,
      ST_ACK,
      ST_SEL,
      ST_CAP,
      ST_SEND
   } dbg_state_e;

   // States in which a new command byte may be taken from the UART
   function automatic logic is_open(input dbg_state_e s);
      return (s == ST_IDLE) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/dbg_word_ser.sv
// Word-to-byte serializer: loads a DW-bit word and emits DW/8 bytes MSB first
// over valid/ready; done flags the handshake of the last byte.
module dbg_word_ser #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] word,
   input  logic          ready,
   output logic          valid,
   output logic [7:0]    data,
   output logic          done
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

   logic [DW-1:0] shreg_q;
   logic [CW-1:0] cnt_q;
   logic          last_c;

   assign last_c = (cnt_q == CW'(NB - 1));
   assign data   = shreg_q[DW-1 -: 8];
   assign done   = valid && ready && last_c;

   // Byte counter stops on the last byte; only a new load restarts it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         valid   <= 1'b0;
      end else if (load) begin
         shreg_q <= word;
         cnt_q   <= '0;
         valid   <= 1'b1;
      end else if (valid && ready) begin
         if (last_c) begin
            valid <= 1'b0;
         end else begin
            shreg_q <= shreg_q << 8;
            cnt_q   <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/cpu_dbg_ctrl.sv
// Debug sequencer: UART command bytes drive core run/halt/step/reset and a
// register dump. Optional CPU_DBG_PC_DUMP_EN prefixes the dump with cpu_pc.
module cpu_dbg_ctrl
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned DW         = 32,
   parameter int unsigned NREG       = 32,
   parameter int unsigned RST_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             cpu_clk_en,
   output logic             cpu_rst,
   output logic [IDX_W-1:0] dbg_reg_index,
   input  logic [DW-1:0]    dbg_reg_data,
   input  logic [7:0]       cpu_pc,
   output logic             busy
);

   localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

   dbg_state_e     state_q;
   logic [RCW-1:0] rst_cnt_q;
   logic           run_q;
   logic           echo_pend_q;
   logic           dump_pend_q;
   logic           ack_valid_q;
   logic [7:0]     ack_data_q;

   logic           ser_load;
   logic           ser_valid;
   logic           ser_done;
   logic [7:0]     ser_data;

   assign ser_load = (state_q == ST_CAP);

   dbg_word_ser #(.DW(DW)) u_ser (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ser_load),
      .word  (dbg_reg_data),
      .ready (tx_ready),
      .valid (ser_valid),
      .data  (ser_data),
      .done  (ser_done)
   );

   // Echo byte and serializer never drive the link at the same time
   assign tx_valid = ack_valid_q | ser_valid;
   assign tx_data  = ack_valid_q ? ack_data_q : ser_data;

`ifndef CPU_DBG_PC_DUMP_EN
   logic unused_pc;
   assign unused_pc = ^cpu_pc;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RST;
         rst_cnt_q     <= '0;
         run_q         <= 1'b0;
         echo_pend_q   <= 1'b0;
         dump_pend_q   <= 1'b0;
         ack_valid_q   <= 1'b0;
         ack_data_q    <= '0;
         rx_ready      <= 1'b0;
         busy          <= 1'b1;
         cpu_clk_en    <= 1'b0;
         cpu_rst       <= 1'b1;
         dbg_reg_index <= '0;
      end else begin
         case (state_q)
            ST_RST: begin
               if (rst_cnt_q == RCW'(RST_CYCLES)) begin
                  cpu_rst    <= 1'b0;
                  cpu_clk_en <= 1'b0;
                  if (echo_pend_q) begin
                     echo_pend_q <= 1'b0;
                     ack_valid_q <= 1'b1;
                     state_q     <= ST_ACK;
                  end else begin
                     state_q  <= ST_IDLE;
                     busy     <= 1'b0;
                     rx_ready <= 1'b1;
                  end
               end else begin
                  rst_cnt_q  <= rst_cnt_q + RCW'(1);
                  cpu_rst    <= 1'b1;
                  cpu_clk_en <= 1'b1;
               end
            end

            ST_IDLE, ST_RUN: begin
               if (rx_valid && rx_ready) begin
                  rx_ready <= 1'b0;
                  busy     <= 1'b1;
                  case (rx_data)
                     CMD_RUN: begin
                        run_q       <= 1'b1;
                        cpu_clk_en  <= 1'b1;
                        ack_data_q  <= CMD_RUN;
                        ack_valid_q <= 1'b1;
                        state_q     <= ST_ACK;
                     end
                     CMD_HALT: begin
                        run_q       <= 1'b0;
                        cpu_clk_en  <= 1'b0;
                        ack_data_q  <= CMD_HALT;
                        ack_valid_q <= 1'b1;
                        state_q     <= ST_ACK;
                     end
                     CMD_STEP: begin
                        run_q      <= 1'b0;
                        cpu_clk_en <= 1'b1;
                        ack_data_q <= CMD_STEP;
                        state_q    <= ST_STEP;
                     end
                     CMD_RST: begin
                        run_q       <= 1'b0;
                        cpu_rst     <= 1'b1;
                        cpu_clk_en  <= 1'b1;
                        rst_cnt_q   <= RCW'(1);
                        echo_pend_q <= 1'b1;
                        ack_data_q  <= CMD_RST;
                        state_q     <= ST_RST;
                     end
                     CMD_DUMP: begin
                        run_q         <= 1'b0;
                        cpu_clk_en    <= 1'b0;
                        dbg_reg_index <= '0;
`ifdef CPU_DBG_PC_DUMP_EN
                        ack_data_q    <= cpu_pc;
                        ack_valid_q   <= 1'b1;
                        dump_pend_q   <= 1'b1;
                        state_q       <= ST_ACK;
`else
                        state_q       <= ST_SEL;
`endif
                     end
                     default: begin
                        ack_data_q  <= ERR_REPLY;
                        ack_valid_q <= 1'b1;
                        state_q     <= ST_ACK;
                     end
                  endcase
               end
            end

            ST_STEP: begin
               cpu_clk_en  <= 1'b0;
               ack_valid_q <= 1'b1;
               state_q     <= ST_ACK;
            end

            ST_ACK: begin
               if (tx_ready) begin
                  ack_valid_q <= 1'b0;
                  if (dump_pend_q) begin
                     dump_pend_q   <= 1'b0;
                     dbg_reg_index <= '0;
                     state_q       <= ST_SEL;
                  end else begin
                     state_q  <= run_q ? ST_RUN : ST_IDLE;
                     busy     <= 1'b0;
                     rx_ready <= 1'b1;
                  end
               end
            end

            ST_SEL: state_q <= ST_CAP;

            ST_CAP: state_q <= ST_SEND;

            // Index saturates on the last register; the dump ends there
            ST_SEND: begin
               if (ser_done) begin
                  if (dbg_reg_index == IDX_W'(NREG - 1)) begin
                     state_q  <= ST_IDLE;
                     busy     <= 1'b0;
                     rx_ready <= 1'b1;
                  end else begin
                     dbg_reg_index <= dbg_reg_index + IDX_W'(1);
                     state_q       <= ST_SEL;
                  end
               end
            end

            default: begin
               state_q <= ST_RST;
               busy    <= 1'b1;
            end
         endcase
         if (is_open(state_q) && !(rx_valid && rx_ready)) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
// Directed self-checking bench for cpu_dbg_ctrl with a simple core register model.
module tb_cpu_dbg_ctrl;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        cpu_clk_en;
   logic        cpu_rst;
   logic [4:0]  dbg_reg_index;
   logic [31:0] dbg_reg_data;
   logic [7:0]  cpu_pc;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   bit pat_b    = 1'b0;
   logic [7:0] got [0:255];

   localparam logic [7:0] PC_VAL = 8'hA5;

   cpu_dbg_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .cpu_clk_en    (cpu_clk_en),
      .cpu_rst       (cpu_rst),
      .dbg_reg_index (dbg_reg_index),
      .dbg_reg_data  (dbg_reg_data),
      .cpu_pc        (cpu_pc),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core register file: value appears one cycle after the index
   logic [7:0] idx8;
   assign idx8 = 8'(dbg_reg_index);
   always @(posedge clk) begin
      if (pat_b) dbg_reg_data <= {idx8, idx8 + 8'h40, idx8 + 8'h80, idx8 + 8'hC0};
      else       dbg_reg_data <= 32'(dbg_reg_index) * 32'h01010101;
   end

   function automatic logic [7:0] exp_byte(input int k);
      int j = k;
`ifdef CPU_DBG_PC_DUMP_EN
      if (k == 0) return PC_VAL;
      j = k - 1;
`endif
      if (pat_b) return 8'((j / 4) + 64 * (j % 4));
      return 8'(j / 4);
   endfunction

   // Offers a byte and returns on the falling edge after it was accepted
   task automatic send_cmd(input logic [7:0] b);
      int g = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (!rx_ready) begin
         checks++; failures++;
         $display("FAIL send_cmd_timeout cmd=%h rx_ready=%b exp=1", b, rx_ready);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic run_dump(input bit toggle, output int nbytes, output int nbad,
                           output int nstall, output int ncyc);
      logic pv, pr;
      logic [7:0] pd;
      nbytes = 0; nbad = 0; nstall = 0; ncyc = 0;
      pv = 1'b0; pr = 1'b0; pd = 8'h00;
      tx_ready = 1'b1;
      cpu_pc   = PC_VAL;
      send_cmd(8'h44);
      cpu_pc   = ~PC_VAL;
      while (!rx_ready && ncyc < 2000) begin
         if (pv && !pr && (!tx_valid || tx_data !== pd)) nstall++;
         if (toggle) tx_ready = ~tx_ready;
         if (tx_valid && tx_ready) begin
            if (nbytes < 256) got[nbytes] = tx_data;
            if (tx_data !== exp_byte(nbytes)) nbad++;
            nbytes++;
         end
         pv = tx_valid; pr = tx_ready; pd = tx_data;
         ncyc++;
         @(negedge clk);
      end
      tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      int n_on = 0;
      int g = 0;
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; cpu_pc = PC_VAL;
      repeat (3) @(negedge clk);
      checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      checks++; if (cpu_clk_en !== 1'b0) begin failures++; $display("FAIL reset_clk_en got=%b exp=0", cpu_clk_en); end
      checks++; if (dbg_reg_index !== 5'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", dbg_reg_index); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
      checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
      rst_n = 1'b1;
      while (!rx_ready && g < 50) begin
         if (cpu_rst === 1'b1 && cpu_clk_en === 1'b1) n_on++;
         g++;
         @(negedge clk);
      end
      checks++; if (n_on != 4) begin failures++; $display("FAIL reset_rst_cycles got=%0d exp=4", n_on); end
      checks++; if (cpu_rst !== 1'b0 || cpu_clk_en !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
         failures++; $display("FAIL reset_idle got=rst%b en%b busy%b rdy%b exp=rst0 en0 busy0 rdy1", cpu_rst, cpu_clk_en, busy, rx_ready);
      end
   endtask

   task automatic test_step();
      tx_ready = 1'b0;
      send_cmd(8'h53);
      checks++; if (cpu_clk_en !== 1'b1 || tx_valid !== 1'b0) begin
         failures++; $display("FAIL step_pulse got=en%b txv%b exp=en1 txv0", cpu_clk_en, tx_valid);
      end
      @(negedge clk);
      checks++; if (cpu_clk_en !== 1'b0) begin failures++; $display("FAIL step_pulse_end got=%b exp=0", cpu_clk_en); end
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h53) begin
         failures++; $display("FAIL step_echo got=v%b d%h exp=v1 d53", tx_valid, tx_data);
      end
      rx_data = 8'h52; rx_valid = 1'b1;
      @(negedge clk);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h53 || rx_ready !== 1'b0) begin
         failures++; $display("FAIL step_stall got=v%b d%h rdy%b exp=v1 d53 rdy0", tx_valid, tx_data, rx_ready);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || cpu_clk_en !== 1'b0) begin
         failures++; $display("FAIL step_ack_done got=v%b rdy%b en%b exp=v0 rdy1 en0", tx_valid, rx_ready, cpu_clk_en);
      end
   endtask

   task automatic test_run_halt();
      int drops = 0;
      tx_ready = 1'b1;
      send_cmd(8'h52);
      checks++; if (cpu_clk_en !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h52) begin
         failures++; $display("FAIL run_echo got=en%b v%b d%h exp=en1 v1 d52", cpu_clk_en, tx_valid, tx_data);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if (cpu_clk_en !== 1'b1) drops++;
         @(negedge clk);
      end
      checks++; if (drops != 0) begin failures++; $display("FAIL run_continuous got=%0d drops exp=0", drops); end
      send_cmd(8'h48);
      checks++; if (cpu_clk_en !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h48) begin
         failures++; $display("FAIL halt_echo got=en%b v%b d%h exp=en0 v1 d48", cpu_clk_en, tx_valid, tx_data);
      end
      @(negedge clk);
      checks++; if (rx_ready !== 1'b1 || cpu_clk_en !== 1'b0) begin
         failures++; $display("FAIL halt_idle got=rdy%b en%b exp=rdy1 en0", rx_ready, cpu_clk_en);
      end
   endtask

   task automatic test_bad_cmd();
      tx_ready = 1'b1;
      send_cmd(8'h52);
      @(negedge clk);
      send_cmd(8'h7A);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F || cpu_clk_en !== 1'b1) begin
         failures++; $display("FAIL bad_reply got=v%b d%h en%b exp=v1 d3f en1", tx_valid, tx_data, cpu_clk_en);
      end
      @(negedge clk);
      checks++; if (rx_ready !== 1'b1 || cpu_clk_en !== 1'b1) begin
         failures++; $display("FAIL bad_keeps_run got=rdy%b en%b exp=rdy1 en1", rx_ready, cpu_clk_en);
      end
      send_cmd(8'h48);
      @(negedge clk);
   endtask

   task automatic test_core_reset();
      int n_on = 0;
      int g = 0;
      tx_ready = 1'b1;
      send_cmd(8'h50);
      while (cpu_rst === 1'b1 && g < 20) begin
         if (cpu_clk_en === 1'b1) n_on++;
         g++;
         @(negedge clk);
      end
      checks++; if (n_on != 4) begin failures++; $display("FAIL core_rst_cycles got=%0d exp=4", n_on); end
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h50 || cpu_clk_en !== 1'b0) begin
         failures++; $display("FAIL core_rst_echo got=v%b d%h en%b exp=v1 d50 en0", tx_valid, tx_data, cpu_clk_en);
      end
      @(negedge clk);
      checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL core_rst_idle got=%b exp=1", rx_ready); end
   endtask

   task automatic test_dump_toggle();
      int nb, nbad, nst, ncyc, off;
      int exp_n = 128;
      logic [31:0] r5;
`ifdef CPU_DBG_PC_DUMP_EN
      exp_n = 129;
`endif
      off = exp_n - 128;
      pat_b = 1'b0;
      run_dump(1'b1, nb, nbad, nst, ncyc);
      checks++; if (nb != exp_n) begin failures++; $display("FAIL dump_count got=%0d exp=%0d", nb, exp_n); end
      checks++; if (nbad != 0) begin failures++; $display("FAIL dump_bytes got=%0d wrong exp=0", nbad); end
      checks++; if (nst != 0) begin failures++; $display("FAIL dump_stall_stable got=%0d changes exp=0", nst); end
      r5 = {got[off + 20], got[off + 21], got[off + 22], got[off + 23]};
      checks++; if (r5 !== 32'h05050505) begin failures++; $display("FAIL dump_reg5 got=%h exp=05050505", r5); end
`ifdef CPU_DBG_PC_DUMP_EN
      checks++; if (got[0] !== PC_VAL) begin failures++; $display("FAIL dump_pc got=%h exp=%h", got[0], PC_VAL); end
`endif
   endtask

   task automatic test_back_to_back();
      int nb, nbad, nst, ncyc;
      int exp_c = 192;
`ifdef CPU_DBG_PC_DUMP_EN
      exp_c = 193;
`endif
      pat_b = 1'b1;
      run_dump(1'b0, nb, nbad, nst, ncyc);
      checks++; if (ncyc != exp_c) begin failures++; $display("FAIL b2b_cycles got=%0d exp=%0d", ncyc, exp_c); end
      checks++; if (nbad != 0) begin failures++; $display("FAIL b2b_msb_first got=%0d wrong exp=0", nbad); end
      checks++; if (dbg_reg_index !== 5'd31) begin failures++; $display("FAIL b2b_index_sat got=%0d exp=31", dbg_reg_index); end
      pat_b = 1'b0;
   endtask

   task automatic test_reset_mid_dump();
      int g = 0;
      int n_on = 0;
      int nb, nbad, nst, ncyc;
      int exp_n = 128;
`ifdef CPU_DBG_PC_DUMP_EN
      exp_n = 129;
`endif
      tx_ready = 1'b1;
      send_cmd(8'h44);
      while (dbg_reg_index !== 5'd10 && g < 500) begin
         @(negedge clk);
         g++;
      end
      checks++; if (dbg_reg_index !== 5'd10) begin failures++; $display("FAIL mid_reach_reg10 got=%0d exp=10", dbg_reg_index); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (tx_valid !== 1'b0 || cpu_rst !== 1'b1 || cpu_clk_en !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b0) begin
         failures++; $display("FAIL mid_abort got=v%b rst%b en%b busy%b rdy%b exp=v0 rst1 en0 busy1 rdy0",
                              tx_valid, cpu_rst, cpu_clk_en, busy, rx_ready);
      end
      checks++; if (dbg_reg_index !== 5'd0) begin failures++; $display("FAIL mid_index got=%0d exp=0", dbg_reg_index); end
      @(negedge clk);
      rst_n = 1'b1;
      g = 0;
      while (!rx_ready && g < 50) begin
         if (cpu_rst === 1'b1 && cpu_clk_en === 1'b1) n_on++;
         g++;
         @(negedge clk);
      end
      checks++; if (n_on != 4) begin failures++; $display("FAIL mid_rst_rerun got=%0d exp=4", n_on); end
      run_dump(1'b0, nb, nbad, nst, ncyc);
      checks++; if (nb != exp_n || nbad != 0) begin
         failures++; $display("FAIL mid_redump got=%0d bytes %0d wrong exp=%0d bytes 0 wrong", nb, nbad, exp_n);
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_run_halt();
      test_bad_cmd();
      test_core_reset();
      test_dump_toggle();
      test_back_to_back();
      test_reset_mid_dump();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
